// File: rtl/pdm_decimator_if.sv
// Sample output channel of the PDM decimator: registered sample, valid/ready
// handshake and the sticky overrun flag.
interface pdm_decimator_if #(
    parameter int SAMPLE_W = 11
);
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid;
    logic                sample_ready;
    logic                overrun;

    modport master (
        output sample_out,
        output sample_valid,
        output overrun,
        input  sample_ready
    );

    modport slave (
        input  sample_out,
        input  sample_valid,
        input  overrun,
        output sample_ready
    );
endinterface

// File: rtl/pdm_decimator.sv
// PDM-to-PCM decimator: counts ones over DECIM-bit windows (first-order sinc).
// Define PDM_DEC_CIC2_EN to replace the boxcar with a second-order CIC filter.
module pdm_decimator #(
    parameter int DECIM    = 32,
    parameter int SAMPLE_W = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pdm_in,
    input  logic            enable,
    pdm_decimator_if.master smp
);

    localparam int PH_W = $clog2(DECIM);
`ifdef PDM_DEC_CIC2_EN
    localparam int RES_W = 2 * PH_W + 1;
`else
    localparam int RES_W = PH_W + 1;
`endif
    localparam logic [PH_W-1:0] PHASE_LAST = PH_W'(DECIM - 1);
    localparam logic [PH_W-1:0] PHASE_ONE  = PH_W'(1);

    // Reject configurations the window and result arithmetic cannot represent.
    generate
        if ((DECIM < 4) || (DECIM > 256) || ((1 << PH_W) != DECIM)) begin : g_bad_decim
            $error("pdm_decimator: DECIM must be a power of two in 4..256");
        end
        if (SAMPLE_W < RES_W) begin : g_bad_width
            $error("pdm_decimator: SAMPLE_W too narrow for the filter result");
        end
    endgenerate

    logic [PH_W-1:0]     phase_r;
    logic                wc_s;
    logic [RES_W-1:0]    pdm_ext_s;
    logic [RES_W-1:0]    result_s;
    logic [SAMPLE_W-1:0] result_ext_s;
    logic [SAMPLE_W-1:0] sample_out_r;
    logic                sample_valid_r;
    logic                overrun_r;

    // Window-complete detection and input bit widening.
    always_comb begin
        pdm_ext_s = {{(RES_W-1){1'b0}}, pdm_in};
        if (enable && (phase_r == PHASE_LAST)) begin
            wc_s = 1'b1;
        end else begin
            wc_s = 1'b0;
        end
    end

    // Phase counter; DECIM is a power of two so the natural wrap ends the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r <= {PH_W{1'b0}};
        end else if (enable) begin
            phase_r <= phase_r + PHASE_ONE;
        end else begin
            phase_r <= phase_r;
        end
    end

`ifdef PDM_DEC_CIC2_EN
    logic [RES_W-1:0] i1_r;
    logic [RES_W-1:0] i2_r;
    logic [RES_W-1:0] d1_r;
    logic [RES_W-1:0] d2_r;
    logic [RES_W-1:0] i1_new_s;
    logic [RES_W-1:0] i2_new_s;
    logic [RES_W-1:0] c1_s;
    logic [RES_W-1:0] c2_s;

    // Integrator and comb datapath; all arithmetic wraps modulo 2^RES_W.
    always_comb begin
        i1_new_s = i1_r + pdm_ext_s;
        i2_new_s = i2_r + i1_new_s;
        c1_s     = i2_new_s - d1_r;
        c2_s     = c1_s - d2_r;
        result_s = c2_s;
    end

    // Integrators run on every enabled bit; comb delays update once per window.
    always_ff @(posedge clk) begin
        if (reset) begin
            i1_r <= {RES_W{1'b0}};
            i2_r <= {RES_W{1'b0}};
            d1_r <= {RES_W{1'b0}};
            d2_r <= {RES_W{1'b0}};
        end else if (enable) begin
            i1_r <= i1_new_s;
            i2_r <= i2_new_s;
            if (wc_s) begin
                d1_r <= i2_new_s;
                d2_r <= c1_s;
            end else begin
                d1_r <= d1_r;
                d2_r <= d2_r;
            end
        end else begin
            i1_r <= i1_r;
            i2_r <= i2_r;
            d1_r <= d1_r;
            d2_r <= d2_r;
        end
    end
`else
    logic [RES_W-1:0] acc_r;

    // Window total includes the bit arriving in the completing cycle.
    always_comb begin
        result_s = acc_r + pdm_ext_s;
    end

    // Ones accumulator, cleared on the same edge that publishes the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= {RES_W{1'b0}};
        end else if (enable) begin
            if (wc_s) begin
                acc_r <= {RES_W{1'b0}};
            end else begin
                acc_r <= result_s;
            end
        end else begin
            acc_r <= acc_r;
        end
    end
`endif

    // Zero-extend the filter result to the output width.
    always_comb begin
        result_ext_s               = {SAMPLE_W{1'b0}};
        result_ext_s[RES_W-1:0]    = result_s;
    end

    // Single-entry output register: a new window always wins over backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out_r   <= {SAMPLE_W{1'b0}};
            sample_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else if (wc_s) begin
            sample_out_r   <= result_ext_s;
            sample_valid_r <= 1'b1;
            if (sample_valid_r && !smp.sample_ready) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end else if (sample_valid_r && smp.sample_ready) begin
            sample_out_r   <= sample_out_r;
            sample_valid_r <= 1'b0;
            overrun_r      <= overrun_r;
        end else begin
            sample_out_r   <= sample_out_r;
            sample_valid_r <= sample_valid_r;
            overrun_r      <= overrun_r;
        end
    end

    assign smp.sample_out   = sample_out_r;
    assign smp.sample_valid = sample_valid_r;
    assign smp.overrun      = overrun_r;

endmodule

// File: doc/pdm_decimator.md
# pdm_decimator

Downstream companion to the first-order PDM modulator. Consumes the 1-bit pulse-density stream (or an external PDM microphone/loopback bit) and decimates it into multi-bit PCM samples by counting ones over fixed windows of DECIM input bits. Samples leave through a single-entry valid/ready output register. Overruns are flagged, never stalled. The bit-exact counting mode lets a bench close the loop around the modulator (input code N of 32 gives N ones per 32-bit window).

## Interface
Parameters:
- DECIM, 32: decimation ratio. Power of two, 4..256.
- SAMPLE_W, 11: width of sample_out. Must be ≥ log2(DECIM)+1, or ≥ 2·log2(DECIM)+1 when CIC2 is compiled in. Results are zero-extended to this width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  one clock; reset is synchronous and active-high.
- pdm_in  input  1  PDM bit; sampled on clk when enable=1.
- enable  input  1  input-rate qualifier. When 0, window state holds; the handshake still runs.
- sample_out  output  SAMPLE_W  decimated sample. Reset 0.
- sample_valid  output  1  sample_out holds an unconsumed sample. Reset 0.
- sample_ready  input  1  consumer accepts sample_out when valid&ready.
- overrun  output  1  sticky flag: an unconsumed sample was overwritten. Reset 0. Cleared only by reset.

## Operation
Window logic:
- phase counter runs 0..DECIM-1 and advances only on enabled cycles. It wraps to 0 after DECIM-1.
- An enabled cycle with phase==DECIM-1 is a window-complete event (wc).

Boxcar mode (default):
- acc accumulates pdm_in on each enabled cycle.
- On wc, result = acc + pdm_in, and acc clears to 0 on the same edge.
- result ranges 0..DECIM.

Output register, evaluated each edge in this priority:
- reset: all state and outputs go to 0.
- wc:
  - sample_out ← result and sample_valid ← 1.
  - If sample_valid=1 and sample_ready=0 in that cycle, overrun ← 1 (old sample lost).
  - If the old sample is consumed in the same cycle, there is no overrun.
- Otherwise, valid&ready: sample_valid ← 0; sample_out holds its value.
- sample_out is stable while sample_valid=1 and no wc occurs.

Other rules:
- Reset mid-window discards the partial window, and phase restarts at 0.
- The enable=0 cycle immediately before the last window bit delays wc; it does not cancel it.

## Timing
- Latency: the edge that captures the window's last bit also loads sample_out. sample_valid is high in the following cycle.
- Output rate: one sample per DECIM enabled cycles. With enable held high, the first wc occurs at the DECIM-th edge after reset deasserts.
- Throughput: the consumer may hold sample_ready=1 permanently with zero bubbles.
- sample_ready is never combinationally routed to any output.

## Configuration
- PDM_DEC_CIC2_EN undefined: boxcar counting as above (first-order sinc).
- PDM_DEC_CIC2_EN defined: the filter is a second-order CIC. The window, handshake and overrun logic are unchanged.
  - Register width is W = 2·log2(DECIM)+1, with modular wrap.
  - Integrators, on each enabled cycle: i1 ← i1 + pdm_in, then i2 ← i2 + i1_new.
  - On wc, using i2_new:
    - c1 = i2 − d1, then d1 ← i2.
    - c2 = c1 − d2, then d2 ← c1.
    - result = c2, range 0..DECIM².
  - Reset clears i1, i2, d1 and d2.
  - The first output after reset is a start-up transient; valid output is guaranteed from the second sample onward.

## Test plan
- Boxcar, DECIM=32, pdm_in=1 constant, ready=1:
  - first sample_valid pulse occurs 33 cycles after reset release with sample_out=32.
  - each later pulse is spaced 32 cycles apart, value 32, overrun=0.
- Closed loop, boxcar: pdm_core with input 8 (write_en pulsed once) drives pdm_in → every sample = 8. With input 0 → every sample = 0.
- Backpressure: ready=0 across two wc events → overrun=1 after the second; sample_out = second window's value; valid stays 1. Then ready=1 for one cycle → valid=0, overrun stays 1.
- Same-cycle consume: ready asserted exactly in the wc cycle with valid=1 → new sample loaded, valid stays 1, overrun=0.
- enable gating plus mid-window reset:
  - alternating 1/0 input with enable low every other cycle → samples of 16, spaced 64 cycles apart.
  - reset at phase 10 → outputs 0, and the next sample appears 32 enabled cycles after release.
- PDM_DEC_CIC2_EN, DECIM=32, pdm_in=1 constant: sample 1 = 528, then sample 2 and all later samples = 1024.
